reg_writeback: RTL and testbench

Write-back sequencer for the multi-cycle datapath; it is the producer side of the register bank's write port. It accepts completed-instruction results over a valid/ready handshake, resolves destination register and result source, queues them in a small in-order buffer, and drains one write per cycle into the register bank whenever the shared write port grants. It also reports pending destinations so the control unit can stall reads of registers that are not yet written.

---
 rtl/reg_wb_pkg.sv | 28 ++
 rtl/reg_writeback_if.sv | 55 +++++
 rtl/reg_wb_queue.sv | 100 ++++++++++
 rtl/reg_writeback.sv | 106 ++++++++++
 tb/tb_reg_writeback.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared types and constants for the write-back sequencer.
// Holds select enums, fixed register numbers and the queued entry layout.
package reg_wb_pkg;

    typedef enum logic [1:0] {
        DST_RD   = 2'b00,
        DST_RT   = 2'b01,
        DST_RA   = 2'b10,
        DST_NONE = 2'b11
    } dst_sel_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10,
        SRC_LUI = 2'b11
    } src_sel_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: result intake handshake plus register-bank write port.
// master = producer/register-bank side, slave = write-back sequencer.
interface reg_writeback_if;

    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_dst_sel;
    logic [4:0]  wb_rd;
    logic [4:0]  wb_rt;
    logic [1:0]  wb_src_sel;
    logic [31:0] wb_alu;
    logic [31:0] wb_mem;
    logic [31:0] wb_pc4;
    logic [15:0] wb_imm16;

    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        rf_wr_ready;

    modport master (
        output wb_valid,
        input  wb_ready,
        output wb_dst_sel,
        output wb_rd,
        output wb_rt,
        output wb_src_sel,
        output wb_alu,
        output wb_mem,
        output wb_pc4,
        output wb_imm16,
        input  rf_wr_en,
        input  rf_wr_addr,
        input  rf_wr_data,
        output rf_wr_ready
    );

    modport slave (
        input  wb_valid,
        output wb_ready,
        input  wb_dst_sel,
        input  wb_rd,
        input  wb_rt,
        input  wb_src_sel,
        input  wb_alu,
        input  wb_mem,
        input  wb_pc4,
        input  wb_imm16,
        output rf_wr_en,
        output rf_wr_addr,
        output rf_wr_data,
        input  rf_wr_ready
    );

endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order write FIFO with associative destination match.
// Ports: clk/reset, push entry, pop, head entry, count, rs/rt lookup hits;
// with REG_WB_BYPASS_EN also youngest-match data for rs/rt.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  wb_entry_t     push,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    output logic          rs_hit,
    output logic          rt_hit
`ifdef REG_WB_BYPASS_EN
    ,
    output logic [31:0]   rs_data,
    output logic [31:0]   rt_data
`endif
);

    logic [AW-1:0]    hd_q;
    logic [AW-1:0]    tl_q;
    logic [CW-1:0]    cnt_q;
    logic [DEPTH-1:0] vld_q;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];

    // Control state: pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            if (pop) begin
                vld_q[hd_q] <= 1'b0;
                hd_q        <= hd_q + AW'(1);
            end
            if (push.valid) begin
                vld_q[tl_q] <= 1'b1;
                tl_q        <= tl_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push.valid) - CW'(pop);
        end
    end

    // Payload is never reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push.valid) begin
            addr_q[tl_q] <= push.addr;
            data_q[tl_q] <= push.data;
        end
    end

    always_comb begin
        head.valid = (cnt_q != '0);
        head.addr  = addr_q[hd_q];
        head.data  = data_q[hd_q];
    end

    assign count = cnt_q;

    // Walk oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        logic [AW-1:0] idx;
        idx    = '0;
        rs_hit = 1'b0;
        rt_hit = 1'b0;
`ifdef REG_WB_BYPASS_EN
        rs_data = '0;
        rt_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = hd_q + AW'(i);
            if (vld_q[idx] && rs != REG_ZERO
                && addr_q[idx] == rs) begin
                rs_hit = 1'b1;
`ifdef REG_WB_BYPASS_EN
                rs_data = data_q[idx];
`endif
            end
            if (vld_q[idx] && rt != REG_ZERO
                && addr_q[idx] == rt) begin
                rt_hit = 1'b1;
`ifdef REG_WB_BYPASS_EN
                rt_data = data_q[idx];
`endif
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-back sequencer feeding the register bank write port.
// Ports: clk, reset (async, active-low), bus (reg_writeback_if.slave:
// wb_* result intake, rf_* write port), hz_rs/hz_rt lookups with
// hz_*_pend flags, wb_count occupancy. Macro REG_WB_BYPASS_EN adds
// fwd_rs_hit/fwd_rs_data and fwd_rt_hit/fwd_rt_data.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_writeback_if.slave         bus,
    input  logic [4:0]             hz_rs,
    input  logic [4:0]             hz_rt,
    output logic                   hz_rs_pend,
    output logic                   hz_rt_pend,
    output logic [$clog2(DEPTH):0] wb_count
`ifdef REG_WB_BYPASS_EN
    ,
    output logic                   fwd_rs_hit,
    output logic [31:0]            fwd_rs_data,
    output logic                   fwd_rt_hit,
    output logic [31:0]            fwd_rt_data
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    dst_sel_t      dsel;
    src_sel_t      ssel;
    logic [4:0]    dst;
    logic [31:0]   res;
    logic          accept;
    logic          pop;
    wb_entry_t     ent;
    wb_entry_t     head;
    logic [CW-1:0] count;

    assign dsel = dst_sel_t'(bus.wb_dst_sel);
    assign ssel = src_sel_t'(bus.wb_src_sel);

    always_comb begin
        dst = REG_ZERO;
        unique case (dsel)
            DST_RD:   dst = bus.wb_rd;
            DST_RT:   dst = bus.wb_rt;
            DST_RA:   dst = REG_RA;
            DST_NONE: dst = REG_ZERO;
        endcase
    end

    always_comb begin
        res = '0;
        unique case (ssel)
            SRC_ALU: res = bus.wb_alu;
            SRC_MEM: res = bus.wb_mem;
            SRC_PC4: res = bus.wb_pc4;
            SRC_LUI: res = {bus.wb_imm16, 16'h0000};
        endcase
    end

    // Held low through reset; full queue refuses without pass-through.
    assign bus.wb_ready = reset && (count < CW'(DEPTH));
    assign accept       = bus.wb_valid && bus.wb_ready;

    // Writes to $0 (incl. "no write") complete the handshake but vanish.
    always_comb begin
        ent.valid = accept && (dst != REG_ZERO);
        ent.addr  = dst;
        ent.data  = res;
    end

    assign pop = bus.rf_wr_en && bus.rf_wr_ready;

    reg_wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push    (ent),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .rs      (hz_rs),
        .rt      (hz_rt),
        .rs_hit  (hz_rs_pend),
        .rt_hit  (hz_rt_pend)
`ifdef REG_WB_BYPASS_EN
        ,
        .rs_data (fwd_rs_data),
        .rt_data (fwd_rt_data)
`endif
    );

`ifdef REG_WB_BYPASS_EN
    assign fwd_rs_hit = hz_rs_pend;
    assign fwd_rt_hit = hz_rt_pend;
`endif

    assign bus.rf_wr_en   = head.valid;
    assign bus.rf_wr_addr = head.addr;
    assign bus.rf_wr_data = head.data;
    assign wb_count       = count;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed bench for reg_writeback with a write scoreboard.
// Build with +define+REG_WB_BYPASS_EN to also exercise the forwarding ports.
module tb_reg_writeback;

    localparam int DEPTH = 2;

    logic                   clk;
    logic                   reset;
    logic [4:0]             hz_rs;
    logic [4:0]             hz_rt;
    logic                   hz_rs_pend;
    logic                   hz_rt_pend;
    logic [$clog2(DEPTH):0] wb_count;
`ifdef REG_WB_BYPASS_EN
    logic                   fwd_rs_hit;
    logic                   fwd_rt_hit;
    logic [31:0]            fwd_rs_data;
    logic [31:0]            fwd_rt_data;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [36:0] sb [$];
    logic [36:0] mon_exp;

    reg_writeback_if bus ();

    reg_writeback #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hz_rs       (hz_rs),
        .hz_rt       (hz_rt),
        .hz_rs_pend  (hz_rs_pend),
        .hz_rt_pend  (hz_rt_pend),
        .wb_count    (wb_count)
`ifdef REG_WB_BYPASS_EN
        ,
        .fwd_rs_hit  (fwd_rs_hit),
        .fwd_rs_data (fwd_rs_data),
        .fwd_rt_hit  (fwd_rt_hit),
        .fwd_rt_data (fwd_rt_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write the bank takes must match the oldest expected.
    always @(negedge clk) begin
        if (bus.rf_wr_en === 1'b1 && bus.rf_wr_ready === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("wr_addr", 32'(bus.rf_wr_addr), 32'(mon_exp[36:32]));
                chk("wr_data", bus.rf_wr_data, mon_exp[31:0]);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] dsel, input logic [4:0] rd,
                           input logic [4:0] rt, input logic [1:0] ssel,
                           input logic [31:0] val, input logic [15:0] imm);
        bus.wb_dst_sel = dsel;
        bus.wb_rd      = rd;
        bus.wb_rt      = rt;
        bus.wb_src_sel = ssel;
        bus.wb_alu     = (ssel == 2'd0) ? val : $urandom();
        bus.wb_mem     = (ssel == 2'd1) ? val : $urandom();
        bus.wb_pc4     = (ssel == 2'd2) ? val : $urandom();
        bus.wb_imm16   = imm;
        bus.wb_valid   = 1'b1;
    endtask

    task automatic send(input logic [1:0] dsel, input logic [4:0] rd,
                        input logic [4:0] rt, input logic [1:0] ssel,
                        input logic [31:0] val, input logic [15:0] imm);
        logic [4:0]  a;
        logic [31:0] d;
        int          n;
        case (dsel)
            2'd0:    a = rd;
            2'd1:    a = rt;
            2'd2:    a = 5'd31;
            default: a = 5'd0;
        endcase
        d = (ssel == 2'd3) ? {imm, 16'h0000} : val;
        present(dsel, rd, rt, ssel, val, imm);
        n = 0;
        while (bus.wb_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_wait_ok", 32'(n < 20), 32'd1);
        @(posedge clk);
        if (a != 5'd0) sb.push_back({a, d});
        #1;
        bus.wb_valid = 1'b0;
        bus.wb_alu   = $urandom();
        bus.wb_mem   = $urandom();
        bus.wb_pc4   = $urandom();
        bus.wb_rd    = 5'($urandom());
        bus.wb_rt    = 5'($urandom());
    endtask

    initial begin
        reset           = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_dst_sel  = 2'd0;
        bus.wb_rd       = 5'd0;
        bus.wb_rt       = 5'd0;
        bus.wb_src_sel  = 2'd0;
        bus.wb_alu      = '0;
        bus.wb_mem      = '0;
        bus.wb_pc4      = '0;
        bus.wb_imm16    = '0;
        bus.rf_wr_ready = 1'b0;
        hz_rs           = 5'd0;
        hz_rt           = 5'd0;

        // Reset state
        idle(3);
        chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst_count", 32'(wb_count), 32'd0);
        chk("rst_ready", 32'(bus.wb_ready), 32'd0);
        chk("rst_rs_pend", 32'(hz_rs_pend), 32'd0);
        chk("rst_rt_pend", 32'(hz_rt_pend), 32'd0);
        reset = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus.wb_ready), 32'd1);

        // Single ALU write to rd=5, one-cycle latency
        bus.rf_wr_ready = 1'b1;
        hz_rs = 5'd5;
        send(2'd0, 5'd5, 5'd7, 2'd0, 32'h0000_00AA, 16'h5555);
        chk("t1_en", 32'(bus.rf_wr_en), 32'd1);
        chk("t1_addr", 32'(bus.rf_wr_addr), 32'd5);
        chk("t1_data", bus.rf_wr_data, 32'h0000_00AA);
        chk("t1_count", 32'(wb_count), 32'd1);
        chk("t1_pend", 32'(hz_rs_pend), 32'd1);
        idle(1);
        chk("t1_drain", 32'(wb_count), 32'd0);
        chk("t1_en_low", 32'(bus.rf_wr_en), 32'd0);
        chk("t1_pend_low", 32'(hz_rs_pend), 32'd0);

        // LUI to rt=8 then JAL to $31, in order
        hz_rt = 5'd8;
        send(2'd1, 5'd3, 5'd8, 2'd3, 32'h0, 16'h1234);
        chk("t2_rt_pend", 32'(hz_rt_pend), 32'd1);
        chk("t2_lui_data", bus.rf_wr_data, 32'h1234_0000);
        send(2'd2, 5'd0, 5'd0, 2'd2, 32'h0000_0040, 16'h0);
        chk("t2_rt_fall", 32'(hz_rt_pend), 32'd0);
        chk("t2_jal_addr", 32'(bus.rf_wr_addr), 32'd31);
        hz_rs = 5'd31;
        #1;
        chk("t2_ra_pend", 32'(hz_rs_pend), 32'd1);
        idle(1);
        chk("t2_drain", 32'(wb_count), 32'd0);

        // Back-pressure: two fill the queue, third waits
        bus.rf_wr_ready = 1'b0;
        hz_rs = 5'd3;
        hz_rt = 5'd4;
        send(2'd0, 5'd3, 5'd0, 2'd0, 32'h0000_0333, 16'h0);
        send(2'd0, 5'd4, 5'd0, 2'd1, 32'h0000_0444, 16'h0);
        chk("t3_full", 32'(wb_count), 32'd2);
        present(2'd0, 5'd6, 5'd0, 2'd0, 32'h0000_0666, 16'h0);
        #1;
        chk("t3_ready_low", 32'(bus.wb_ready), 32'd0);
        chk("t3_rs_pend", 32'(hz_rs_pend), 32'd1);
        chk("t3_rt_pend", 32'(hz_rt_pend), 32'd1);
        idle(2);
        chk("t3_hold_addr", 32'(bus.rf_wr_addr), 32'd3);
        chk("t3_hold_data", bus.rf_wr_data, 32'h0000_0333);
        chk("t3_hold_cnt", 32'(wb_count), 32'd2);
        bus.rf_wr_ready = 1'b1;
        send(2'd0, 5'd6, 5'd0, 2'd0, 32'h0000_0666, 16'h0);
        chk("t3_rs_fall", 32'(hz_rs_pend), 32'd0);
        chk("t3_rt_fall", 32'(hz_rt_pend), 32'd0);
        chk("t3_third", 32'(wb_count), 32'd1);
        idle(1);
        chk("t3_drain", 32'(wb_count), 32'd0);

        // $0 and no-write destinations are swallowed
        hz_rs = 5'd0;
        send(2'd0, 5'd0, 5'd9, 2'd0, 32'hFFFF_FFFF, 16'h0);
        chk("t4_r0_cnt", 32'(wb_count), 32'd0);
        chk("t4_r0_en", 32'(bus.rf_wr_en), 32'd0);
        chk("t4_r0_pend", 32'(hz_rs_pend), 32'd0);
        hz_rs = 5'd9;
        send(2'd3, 5'd9, 5'd9, 2'd0, 32'h0000_0099, 16'h0);
        chk("t4_none_cnt", 32'(wb_count), 32'd0);
        chk("t4_none_pend", 32'(hz_rs_pend), 32'd0);
        send(2'd1, 5'd9, 5'd0, 2'd1, 32'h0000_0999, 16'h0);
        chk("t4_rt0_en", 32'(bus.rf_wr_en), 32'd0);

        // Full queue, then streaming through wrapping pointers
        bus.rf_wr_ready = 1'b0;
        send(2'd0, 5'd10, 5'd0, 2'd0, 32'h0000_00A0, 16'h0);
        send(2'd0, 5'd11, 5'd0, 2'd0, 32'h0000_00B0, 16'h0);
        chk("t5_full", 32'(wb_count), 32'd2);
        bus.rf_wr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(2'd0, 5'(12 + k), 5'd0, 2'd0, 32'h0000_00C0 + k, 16'h0);
            chk("t5_count", 32'(wb_count), 32'd1);
            chk("t5_en", 32'(bus.rf_wr_en), 32'd1);
        end
        idle(2);
        chk("t5_drain", 32'(wb_count), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Two writes to r9 queued, then reset mid-drain
        bus.rf_wr_ready = 1'b0;
        hz_rs = 5'd9;
        hz_rt = 5'd10;
        send(2'd0, 5'd9, 5'd0, 2'd0, 32'h0000_0111, 16'h0);
        send(2'd1, 5'd0, 5'd9, 2'd1, 32'h0000_0222, 16'h0);
        chk("t6_cnt", 32'(wb_count), 32'd2);
        chk("t6_rs_pend", 32'(hz_rs_pend), 32'd1);
        chk("t6_rt_pend", 32'(hz_rt_pend), 32'd0);
`ifdef REG_WB_BYPASS_EN
        chk("t6_fwd_hit", 32'(fwd_rs_hit), 32'd1);
        chk("t6_fwd_data", fwd_rs_data, 32'h0000_0222);
        chk("t6_fwd_rt_hit", 32'(fwd_rt_hit), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("t6_rst_en", 32'(bus.rf_wr_en), 32'd0);
        chk("t6_rst_cnt", 32'(wb_count), 32'd0);
        chk("t6_rst_pend", 32'(hz_rs_pend), 32'd0);
        chk("t6_rst_ready", 32'(bus.wb_ready), 32'd0);
        sb.delete();
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("t6_post_cnt", 32'(wb_count), 32'd0);
        chk("t6_post_en", 32'(bus.rf_wr_en), 32'd0);
        chk("t6_post_pend", 32'(hz_rs_pend), 32'd0);
        bus.rf_wr_ready = 1'b1;
        send(2'd0, 5'd9, 5'd0, 2'd0, 32'h0000_0999, 16'h0);
        chk("t6_new_pend", 32'(hz_rs_pend), 32'd1);
        chk("t6_new_data", bus.rf_wr_data, 32'h0000_0999);
        idle(2);
        chk("end_cnt", 32'(wb_count), 32'd0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
